// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async_fifo family.
package async_fifo_pkg;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_1_if.sv
// Producer/consumer handshake bundle for async_fifo_1.
// Optional overflow/underflow signals exist only when ASYNC_FIFO_1_OVF_EN is defined.
interface async_fifo_1_if #(
  parameter int DSIZE = 8
);
  // A push transfers on a rising edge where winc=1 and wfull=0; a pop transfers
  // where rinc=1 and rempty=0. Requests against the opposite flag are ignored.
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
`ifdef ASYNC_FIFO_1_OVF_EN
  logic             overflow;
  logic             underflow;
`endif

`ifdef ASYNC_FIFO_1_OVF_EN
  modport master (output winc, wdata, rinc, input rdata, wfull, rempty, overflow, underflow);
  modport slave  (input winc, wdata, rinc, output rdata, wfull, rempty, overflow, underflow);
`else
  modport master (output winc, wdata, rinc, input rdata, wfull, rempty);
  modport slave  (input winc, wdata, rinc, output rdata, wfull, rempty);
`endif

endinterface

// File: rtl/async_fifo_1_fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read. Not reset.
module fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/async_fifo_1.sv
// Single-clock FIFO with Gray-coded pointers and registered full/empty flags.
// Define ASYNC_FIFO_1_OVF_EN to add sticky overflow/underflow outputs.
module async_fifo_1
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic           wclk,
  input  logic           wrst,
  async_fifo_1_if.slave  bus
);

  typedef logic [ASIZE:0] ptr_t;

  ptr_t wbin_q, wbin_d;
  ptr_t rbin_q, rbin_d;
  ptr_t rgray_q, rgray_d;
  ptr_t wgray_d;
  logic wfull_q, wfull_d;
  logic rempty_q, rempty_d;
  logic w_acc, r_acc;

  always_comb begin
    w_acc    = bus.winc && !wfull_q;
    r_acc    = bus.rinc && !rempty_q;
    wbin_d   = wbin_q + ptr_t'(w_acc);
    rbin_d   = rbin_q + ptr_t'(r_acc);
    wgray_d  = ptr_t'(bin2gray(32'(wbin_d)));
    rgray_d  = ptr_t'(bin2gray(32'(rbin_d)));
    rempty_d = (rgray_d == wgray_d);
    // Full compares against the pre-update read pointer, as a future
    // synchronised read pointer would lag anyway.
    wfull_d  = (wgray_d == {~rgray_q[ASIZE:ASIZE-1], rgray_q[ASIZE-2:0]});
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      rbin_q   <= '0;
      rgray_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
    end else begin
      wbin_q   <= wbin_d;
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
    end
  end

  fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk   (wclk),
    .we    (w_acc && !wrst),
    .waddr (wbin_q[ASIZE-1:0]),
    .wdata (bus.wdata),
    .raddr (rbin_q[ASIZE-1:0]),
    .rdata (bus.rdata)
  );

  assign bus.wfull  = wfull_q;
  assign bus.rempty = rempty_q;

`ifdef ASYNC_FIFO_1_OVF_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (bus.winc && wfull_q);
    underflow_d = underflow_q || (bus.rinc && rempty_q);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_1.sv
// Scoreboard bench for async_fifo_1 (single clock, 16 x 8).
module tb_async_fifo_1;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;

  logic wclk = 1'b0;
  logic wrst;

  async_fifo_1_if #(.DSIZE(DW)) bus ();

  async_fifo_1 #(.DSIZE(DW), .ASIZE(AW)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int            cnt;
  int            n_checks;
  int            n_fail;
  logic          exp_ovf;
  logic          exp_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_wfull"},  32'(bus.wfull),  32'(cnt == DEPTH));
    check({tag, "_rempty"}, 32'(bus.rempty), 32'(cnt == 0));
  endtask

  task automatic check_ovf(input string tag);
`ifdef ASYNC_FIFO_1_OVF_EN
    check({tag, "_overflow"},  32'(bus.overflow),  32'(exp_ovf));
    check({tag, "_underflow"}, 32'(bus.underflow), 32'(exp_unf));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // Called at posedge+1: drives one cycle of requests, compares the popped word,
  // then advances to the next posedge+1.
  task automatic step(input logic wi, input logic [DW-1:0] wd, input logic ri);
    logic w_ok, r_ok;
    logic [DW-1:0] e;
    bus.winc  = wi;
    bus.wdata = wd;
    bus.rinc  = ri;
    w_ok = wi && (cnt < DEPTH);
    r_ok = ri && (cnt > 0);
    if (wi && cnt == DEPTH) exp_ovf = 1'b1;
    if (ri && cnt == 0)     exp_unf = 1'b1;
    #1;
    if (r_ok) begin
      e = exp_q.pop_front();
      check("rdata", 32'(bus.rdata), 32'(e));
    end
    if (w_ok) exp_q.push_back(wd);
    @(posedge wclk);
    #1;
    cnt = cnt + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
  endtask

  logic [DW-1:0] fill_data [DEPTH];

  initial begin
    fill_data = '{8'd23, 8'd43, 8'd42, 8'd44, 8'd45, 8'd47, 8'd1, 8'd3,
                  8'd11, 8'd4, 8'd54, 8'd65, 8'd77, 8'd89, 8'd99, 8'd121};
    n_checks = 0;
    n_fail   = 0;
    cnt      = 0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;

    // reset: flags valid immediately on assertion and after release
    wrst = 1'b1;
    #1;
    check_flags("rst_assert");
    check_ovf("rst_assert");
    #39;
    wrst = 1'b0;
    @(posedge wclk);
    #1;
    check_flags("rst_release");

    // fill, then two writes while full are dropped
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, fill_data[i], 1'b0);
      check_flags("fill");
    end
    step(1'b1, 8'd142, 1'b0);
    step(1'b1, 8'd44, 1'b0);
    check_flags("full_drop");
    check_ovf("full_drop");

    // drain in order, then one read while empty
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    check_flags("drain");
    step(1'b0, '0, 1'b1);
    check_flags("empty_read");
    check_ovf("empty_read");

    // concurrent push/pop at occupancy 8, crosses pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    check_flags("conc_pre");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'($urandom_range(0, 255)), 1'b1);
      check_flags("conc");
      check("conc_occ", 32'(cnt), 32'd8);
    end

    // full + simultaneous read/write: read accepted, write dropped
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    check_flags("refill");
    step(1'b1, 8'hEE, 1'b1);
    check("fullrd_occ", 32'(cnt), 32'(DEPTH - 1));
    step(1'b0, '0, 1'b0);
    check_flags("fullrd_idle");
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1);
    check_flags("fullrd_drain");

    // mid-operation reset at occupancy 5
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    check_flags("pre_midrst");
    #2;
    wrst = 1'b1;
    #1;
    exp_q.delete();
    cnt     = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_flags("midrst_assert");
    #2;
    wrst = 1'b0;
    @(posedge wclk);
    #1;
    check_flags("midrst_release");
    check_ovf("midrst_release");
    step(1'b1, 8'hA5, 1'b0);
    check_flags("post_rst_write");
    step(1'b0, '0, 1'b1);
    check_flags("post_rst_read");
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/async_fifo_1.md
# async_fifo_1

Parameterized FIFO buffer with Gray-coded pointers and registered full/empty flags. In this revision both pointers run in a single clock domain, so the block serves as a drop-in rate-decoupling buffer between a producer and a consumer that share one clock. Write and read sides keep the push/pop naming of the dual-clock FIFO family. Pointer logic stays Gray-coded, so a later split into two domains needs only synchronizers.

## Interface
Parameters:
- DSIZE, 8, data word width in bits
- ASIZE, 4, address width; depth = 2**ASIZE (16 by default)

Ports (one clock; reset is asynchronous and active-high):
- wclk  input  1  sole clock; all state updates on its rising edge
- wrst  input  1  asynchronous, active-high reset for all pointers and flags
- winc  input  1  write request; accepted when wfull=0
- wdata  input  DSIZE  write data, sampled on the accepting edge
- rinc  input  1  read request; accepted when rempty=0
- rdata  output  DSIZE  word at the current read address (combinational from memory)
- wfull  output  1  FIFO holds 2**ASIZE words
- rempty  output  1  FIFO holds 0 words

## Operation
- Storage: 2**ASIZE x DSIZE register array. The array is not reset.
- Pointers: wbin and rbin are ASIZE+1-bit binary counters, each with a Gray mirror (g = b ^ (b>>1)). The low ASIZE bits of each binary counter address the array.
- Write: if winc && !wfull, then mem[wbin[ASIZE-1:0]] <= wdata and wbin increments. A write while full is dropped silently, and its data is lost.
- Read: rdata = mem[rbin[ASIZE-1:0]] at all times. If rinc && !rempty, rbin increments. A read while empty is ignored.
- Empty: rempty is registered as (next rgray == next wgray).
- Full: wfull is registered as (next wgray == {~rgray[MSB:MSB-1], rgray[MSB-2:0]}), where rgray is the current read pointer.
- Simultaneous rinc and winc: each is qualified independently by the current flags.
  - Neither full nor empty: both proceed, and occupancy is unchanged.
  - Full: only the read proceeds.
  - Empty: only the write proceeds.
- Wrap-around: the pointers roll over modulo 2**(ASIZE+1). The extra MSB distinguishes full from empty.
- Reset (any time, including mid-operation): pointers go to 0, wfull=0, rempty=1, and buffered contents are discarded logically.
  - rdata is don't-care while rempty=1.
  - No transfer is accepted while wrst=1.

## Timing
- Accepted write at edge N: rempty falls after edge N, and the word appears on rdata in the same cycle.
- Accepted read at edge N: rdata shows the next word after edge N, settling combinationally.
- After the 2**ASIZE-th net write at edge N, wfull=1 from edge N onward.
- After the last read at edge N, rempty=1 from edge N onward.
- Flags are registered outputs with no combinational path from winc/rinc.
- Throughput: one write and one read per cycle.

## Configuration
- ASYNC_FIFO_1_OVF_EN defined: adds output ports overflow and underflow.
  - overflow sets on winc && wfull. underflow sets on rinc && rempty.
  - Both flags are sticky until wrst and reset to 0.
- Macro undefined: the ports and logic are absent, and the remaining behaviour is identical.

## Structure
- Shared package async_fifo_pkg holds:
  - bin2gray function
  - default DSIZE/ASIZE constants
- One sub-module, fifo_mem: the dual-port register array with synchronous write and asynchronous read.
- Pointer and flag logic stays in the top module.

## Test plan
- Reset: assert wrst for 40 ns, then release → wfull=0 and rempty=1 immediately on assertion, and the values hold after release.
- Fill: hold winc for 16 cycles with data 23,43,42,44,45,47,1,3,11,4,54,65,77,89,99,121 → wfull=1 after the 16th edge. The following writes of 142 and 44 are dropped.
- Drain: hold rinc with winc=0 → rdata sequence 23,43,42,…,121 in order, and rempty=1 after the 16th read.
- Concurrent: occupancy 8, winc=rinc=1 for 20 cycles → order is preserved, occupancy stays 8, and neither flag asserts; this also exercises pointer wrap.
- Full+read: FIFO full, winc=rinc=1 for one cycle → the read is accepted, the write is dropped, and wfull=0 afterwards.
- Mid-op reset: occupancy 5, pulse wrst → rempty=1, wfull=0; the next write of 0xA5 is read back first. With ASYNC_FIFO_1_OVF_EN defined, overflow and underflow are also checked.
